// File: rtl/axis_peak_lag_search.sv
// Per-channel peak |real| search over the +/-WIN lag window of each AXI-Stream frame.
// Optional macro PLS_PEAK_MAG_EN adds res_mag, the peak magnitude per channel.
module axis_peak_lag_search #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAME_LEN = 4096,
  parameter int unsigned WIN       = 3,
  localparam int unsigned LAG_W    = $clog2(WIN + 1) + 1,
  localparam int unsigned MAG_W    = DATA_W - 1
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [NCH*2*DATA_W-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NCH*LAG_W-1:0]    res_lag,
  output logic [NCH-1:0]          res_zero,
`ifdef PLS_PEAK_MAG_EN
  output logic [NCH*MAG_W-1:0]    res_mag,
`endif
  output logic                    res_overrun,
  output logic                    frame_err,
  output logic                    irq
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, SEARCH, SKIP, PUBLISH} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NCH-1:0][MAG_W-1:0]     max_q, max_d;
  logic [NCH-1:0][LAG_W-1:0]     lag_q, lag_d;
  logic [NCH-1:0][LAG_W-1:0]     res_lag_q, res_lag_d;
  logic [NCH-1:0]                res_zero_q, res_zero_d;
  logic                          res_valid_q, res_valid_d;
  logic                          res_overrun_q, res_overrun_d;
  logic                          frame_err_q, frame_err_d;
  logic                          irq_q, irq_d;
`ifdef PLS_PEAK_MAG_EN
  logic [NCH-1:0][MAG_W-1:0]     res_mag_q, res_mag_d;
`endif

  logic [NCH-1:0][MAG_W-1:0]     mag, cand_max;
  logic [NCH-1:0][LAG_W-1:0]     cand_lag;
  logic [NCH-1:0][DATA_W-1:0]    imag_unused;
  logic                          in_win, last_idx, frame_end, bad_last;

  function automatic logic in_window(input logic [IDX_W-1:0] i);
    return (i <= IDX_W'(WIN)) || (i >= IDX_W'(FRAME_LEN - WIN));
  endfunction

  // |real| with the most negative code saturating to all-ones
  function automatic logic [MAG_W-1:0] mag_of(input logic [DATA_W-1:0] re);
    logic [DATA_W-1:0] neg;
    neg = ~re + DATA_W'(1);
    if (!re[DATA_W-1])     return re[MAG_W-1:0];
    else if (neg[DATA_W-1]) return '1;
    else                   return neg[MAG_W-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      mag[c]         = mag_of(s_axis_tdata[c*2*DATA_W +: DATA_W]);
      imag_unused[c] = s_axis_tdata[c*2*DATA_W + DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    max_d         = max_q;
    lag_d         = lag_q;
    res_lag_d     = res_lag_q;
    res_zero_d    = res_zero_q;
    res_valid_d   = res_valid_q;
    res_overrun_d = res_overrun_q;
    frame_err_d   = 1'b0;
`ifdef PLS_PEAK_MAG_EN
    res_mag_d     = res_mag_q;
`endif
    in_win    = in_window(idx_q);
    last_idx  = (idx_q == IDX_W'(FRAME_LEN - 1));
    frame_end = s_axis_tvalid && last_idx;
    bad_last  = s_axis_tvalid && s_axis_tlast && !last_idx;
    cand_max  = max_q;
    cand_lag  = lag_q;

    // Truncating the index yields the signed lag for both window halves
    for (int c = 0; c < int'(NCH); c++) begin
      if (in_win && (mag[c] > max_q[c])) begin
        cand_max[c] = mag[c];
        cand_lag[c] = LAG_W'(idx_q);
      end
    end

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    if (bad_last) begin
      idx_d       = '0;
      max_d       = '0;
      lag_d       = '0;
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end else if (frame_end) begin
      idx_d     = '0;
      max_d     = '0;
      lag_d     = '0;
      res_lag_d = cand_lag;
      for (int c = 0; c < int'(NCH); c++) res_zero_d[c] = (cand_max[c] == '0);
`ifdef PLS_PEAK_MAG_EN
      res_mag_d = cand_max;
`endif
      if (res_valid_q && !res_ready) res_overrun_d = 1'b1;
      res_valid_d = 1'b1;
      state_d     = PUBLISH;
    end else if (s_axis_tvalid) begin
      idx_d   = idx_q + IDX_W'(1);
      max_d   = cand_max;
      lag_d   = cand_lag;
      state_d = in_window(idx_d) ? SEARCH : SKIP;
    end else if (state_q == PUBLISH) begin
      state_d = IDLE;
    end

    irq_d = res_valid_d;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      max_q         <= '0;
      lag_q         <= '0;
      res_lag_q     <= '0;
      res_zero_q    <= '0;
      res_valid_q   <= 1'b0;
      res_overrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      irq_q         <= 1'b0;
`ifdef PLS_PEAK_MAG_EN
      res_mag_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      max_q         <= max_d;
      lag_q         <= lag_d;
      res_lag_q     <= res_lag_d;
      res_zero_q    <= res_zero_d;
      res_valid_q   <= res_valid_d;
      res_overrun_q <= res_overrun_d;
      frame_err_q   <= frame_err_d;
      irq_q         <= irq_d;
`ifdef PLS_PEAK_MAG_EN
      res_mag_q     <= res_mag_d;
`endif
    end
  end

  assign res_valid   = res_valid_q;
  assign res_lag     = res_lag_q;
  assign res_zero    = res_zero_q;
  assign res_overrun = res_overrun_q;
  assign frame_err   = frame_err_q;
  assign irq         = irq_q;
`ifdef PLS_PEAK_MAG_EN
  assign res_mag     = res_mag_q;
`endif

endmodule

// File: tb/tb_axis_peak_lag_search.sv
// Scoreboard bench for axis_peak_lag_search (NCH=2, DATA_W=16, FRAME_LEN=16, WIN=3).
// Honours PLS_PEAK_MAG_EN when defined by also checking res_mag.
module tb_axis_peak_lag_search;
  localparam int unsigned NCH = 2, DATA_W = 16, FLEN = 16, WIN = 3, LAG_W = 3, MAG_W = 15;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NCH*2*DATA_W-1:0] tdata;
  logic                    tvalid, tlast, res_ready;
  logic                    res_valid, res_overrun, frame_err, irq;
  logic [NCH*LAG_W-1:0]    res_lag;
  logic [NCH-1:0]          res_zero;
`ifdef PLS_PEAK_MAG_EN
  logic [NCH*MAG_W-1:0]    res_mag;
`endif

  axis_peak_lag_search #(.NCH(NCH), .DATA_W(DATA_W), .FRAME_LEN(FLEN), .WIN(WIN)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .res_valid(res_valid), .res_ready(res_ready), .res_lag(res_lag), .res_zero(res_zero),
`ifdef PLS_PEAK_MAG_EN
    .res_mag(res_mag),
`endif
    .res_overrun(res_overrun), .frame_err(frame_err), .irq(irq));

  always #5 clk = ~clk;

  typedef struct { int lag0, lag1, z0, z1, mag0, mag1, ovr; } exp_t;
  exp_t q[$];

  int n_checks = 0, n_errors = 0;
  int exp_ferr = 0, obs_ferr = 0;
  int m_idx = 0;
  bit m_valid = 1'b0, m_ovr = 1'b0;
  int cap [2][FLEN];
  int fr0 [FLEN];
  int fr1 [FLEN];
  logic ferr_prev;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lag_of(input int ch);
    logic signed [LAG_W-1:0] l;
    l = res_lag[ch*LAG_W +: LAG_W];
    return int'(l);
  endfunction

  // Reference: walk the window in arrival order, keep the first strictly-largest magnitude
  function automatic void ref_peak(input int ch, output int lag, output int mag, output int zero);
    int best, blag, m, i;
    best = 0; blag = 0;
    for (int k = 0; k < 2*WIN+1; k++) begin
      i = (k <= WIN) ? k : FLEN - (2*WIN+1) + k;
      m = (cap[ch][i] < 0) ? -cap[ch][i] : cap[ch][i];
      if (m > 32767) m = 32767;
      if (m > best) begin
        best = m;
        blag = (i <= WIN) ? i : i - FLEN;
      end
    end
    lag = blag; mag = best; zero = (best == 0) ? 1 : 0;
  endfunction

  // Drive one cycle and advance the behavioural model by the same beat
  task automatic cycle(input bit v, input bit l, input int r0, input int r1, input bit rdy);
    exp_t e;
    bit   hs;
    tvalid = v; tlast = l; res_ready = rdy;
    tdata  = {16'($urandom), 16'(r1), 16'($urandom), 16'(r0)};
    hs = m_valid && rdy;
    if (v) begin
      if (l && m_idx != FLEN-1) begin
        exp_ferr++;
        m_idx = 0;
      end else begin
        cap[0][m_idx] = r0;
        cap[1][m_idx] = r1;
        if (m_idx == FLEN-1) begin
          ref_peak(0, e.lag0, e.mag0, e.z0);
          ref_peak(1, e.lag1, e.mag1, e.z1);
          if (m_valid && !rdy) begin
            void'(q.pop_back());
            m_ovr = 1'b1;
          end
          e.ovr = int'(m_ovr);
          q.push_back(e);
          m_valid = 1'b1;
          hs = 1'b0;
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
    if (hs) m_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic bit ready_for(input int mode, input bit last);
    return (mode == 1) || (mode == 2 && last) || (mode == 3 && $urandom_range(0, 1) == 1);
  endfunction

  // mode: 0 ready low, 1 ready high, 2 ready only on the last beat, 3 random
  task automatic run_frame(input int mode, input bit gaps, input int bad);
    for (int i = 0; i < FLEN; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 0, 0, ready_for(mode, 1'b0));
      cycle(1'b1, (i == FLEN-1) || (i == bad), fr0[i], fr1[i], ready_for(mode, i == FLEN-1));
      if (i == bad) break;
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < FLEN; i++) begin
      fr0[i] = 0;
      fr1[i] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, int'(res_valid), 0);
    chk({tag, "_lag"}, int'(res_lag), 0);
    chk({tag, "_zero"}, int'(res_zero), 0);
    chk({tag, "_ovr"}, int'(res_overrun), 0);
    chk({tag, "_ferr"}, int'(frame_err), 0);
    chk({tag, "_irq"}, int'(irq), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; res_ready = 1'b0;
    q.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_idx = 0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 5))
      0, 1, 2: return 0;
      3:       return int'($urandom_range(0, 20)) - 10;
      4:       return ($urandom_range(0, 1) == 1) ? -32768 : 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Monitor: pop and compare on every result handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("irq_eq_valid", int'(irq), int'(res_valid));
      chk("frame_err_width", int'(frame_err && ferr_prev), 0);
      ferr_prev <= frame_err;
      if (frame_err) obs_ferr++;
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("res_lag0", lag_of(0), e.lag0);
          chk("res_lag1", lag_of(1), e.lag1);
          chk("res_zero0", int'(res_zero[0]), e.z0);
          chk("res_zero1", int'(res_zero[1]), e.z1);
          chk("res_overrun", int'(res_overrun), e.ovr);
`ifdef PLS_PEAK_MAG_EN
          chk("res_mag0", int'(res_mag[0 +: MAG_W]), e.mag0);
          chk("res_mag1", int'(res_mag[MAG_W +: MAG_W]), e.mag1);
`endif
        end
      end
    end else begin
      ferr_prev <= 1'b0;
    end
  end

  initial begin
    int bad;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("init");
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 0, 0, 1'b0);

    // Peaks on both sides of the window
    clear_frame(); fr0[14] = 500; fr1[2] = -7;
    run_frame(0, 1'b0, -1);
    chk("t1_valid", int'(res_valid), 1);
    chk("t1_lag0", lag_of(0), -2);
    chk("t1_lag1", lag_of(1), 2);
    chk("t1_zero", int'(res_zero), 0);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);
    chk("t1_cleared", int'(res_valid), 0);

    // All-zero frame, irq held until handshake
    clear_frame();
    run_frame(0, 1'b0, -1);
    chk("t2_zero", int'(res_zero), 3);
    chk("t2_lag", int'(res_lag), 0);
    repeat (3) cycle(1'b0, 1'b0, 0, 0, 1'b0);
    chk("t2_irq_held", int'(irq), 1);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);
    chk("t2_irq_clear", int'(irq), 0);

    // Saturated tie keeps the earlier index
    clear_frame(); fr0[1] = -32768; fr0[13] = 32767;
    run_frame(1, 1'b0, -1);
    chk("t3_lag0", lag_of(0), 1);
`ifdef PLS_PEAK_MAG_EN
    chk("t3_mag0", int'(res_mag[0 +: MAG_W]), 32767);
`endif
    cycle(1'b0, 1'b0, 0, 0, 1'b1);

    // Misaligned tlast, then a normal frame
    clear_frame(); fr0[0] = 77;
    run_frame(1, 1'b0, 9);
    chk("t4_ferr", int'(frame_err), 1);
    chk("t4_no_valid", int'(res_valid), 0);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);
    chk("t4_ferr_pulse", int'(frame_err), 0);
    clear_frame(); fr1[15] = -3;
    run_frame(1, 1'b0, -1);
    chk("t4_valid", int'(res_valid), 1);
    chk("t4_lag1", lag_of(1), -1);
    chk("t4_lag0", lag_of(0), 0);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);

    // Overwrite without acknowledge
    clear_frame(); fr0[0] = 5;
    run_frame(0, 1'b0, -1);
    clear_frame(); fr0[3] = 9;
    run_frame(0, 1'b0, -1);
    chk("t5_ovr", int'(res_overrun), 1);
    chk("t5_lag0", lag_of(0), 3);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);
    do_reset();

    // Acknowledge coincident with frame end
    clear_frame(); fr1[1] = 6;
    run_frame(0, 1'b0, -1);
    clear_frame(); fr1[14] = 8;
    run_frame(2, 1'b0, -1);
    chk("t6_valid", int'(res_valid), 1);
    chk("t6_ovr", int'(res_overrun), 0);
    chk("t6_lag1", lag_of(1), -2);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);

    // Reset mid-frame discards the partial maximum
    clear_frame(); fr0[1] = 1000;
    cycle(1'b1, 1'b0, fr0[0], fr1[0], 1'b1);
    cycle(1'b1, 1'b0, fr0[1], fr1[1], 1'b1);
    do_reset();
    clear_frame(); fr1[13] = 4;
    run_frame(1, 1'b0, -1);
    chk("t7_lag0", lag_of(0), 0);
    chk("t7_zero0", int'(res_zero[0]), 1);
    chk("t7_lag1", lag_of(1), -3);
    cycle(1'b0, 1'b0, 0, 0, 1'b1);

    // Randomised frames with gaps, random ready and occasional bad tlast
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < FLEN; i++) begin
        fr0[i] = rnd_sample();
        fr1[i] = rnd_sample();
      end
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FLEN-2)) : -1;
      run_frame(3, 1'b1, bad);
      if (bad >= 0) cycle(1'b0, 1'b0, 0, 0, ready_for(3, 1'b0));
    end

    repeat (20) cycle(1'b0, 1'b0, 0, 0, 1'b1);
    chk("drain_empty", q.size(), 0);
    chk("frame_err_count", obs_ferr, exp_ferr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
